// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Brief    : Shared encodings for the pipeline hazard/control unit.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam logic [1:0] c_ST_RUN     = 2'b00;
    localparam logic [1:0] c_ST_WAIT_MC = 2'b01;
    localparam logic [1:0] c_ST_HALT    = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN     = c_ST_RUN,
        ST_WAIT_MC = c_ST_WAIT_MC,
        ST_HALT    = c_ST_HALT
    } state_t;

    localparam logic [1:0] c_FWD_RF    = 2'b00;
    localparam logic [1:0] c_FWD_EXMEM = 2'b10;
    localparam logic [1:0] c_FWD_MEMWB = 2'b01;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
    } pipe_ctrl_t;

    // Free-flowing pipeline: everything advances, nothing is squashed.
    localparam pipe_ctrl_t c_CTRL_FLOW = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

    localparam pipe_ctrl_t c_CTRL_FROZEN = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0
    };

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_unit
//  Brief    : Combinational EX operand forwarding and load-use detection.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_idex_rd,
    input  logic              i_idex_memread,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_regwrite,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_regwrite,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_load_use
);

    // The younger EX/MEM result wins; x0 is hard-wired and never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] rs);
        if (i_exmem_regwrite && (i_exmem_rd != '0) && (i_exmem_rd == rs))
            return c_FWD_EXMEM;
        else if (i_memwb_regwrite && (i_memwb_rd != '0) && (i_memwb_rd == rs))
            return c_FWD_MEMWB;
        else
            return c_FWD_RF;
    endfunction

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign o_fwd_a    = fwd_sel(i_ex_rs1);
    assign o_fwd_b    = fwd_sel(i_ex_rs2);
    assign w_rs1_hit  = i_id_use_rs1 && (i_idex_rd == i_id_rs1);
    assign w_rs2_hit  = i_id_use_rs2 && (i_idex_rd == i_id_rs2);
    assign o_load_use = i_idex_memread && (i_idex_rd != '0) && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Hazard/control FSM for a 5-stage pipeline: stalls, flushes,
//             multicycle sequencing with watchdog, debug halt, perf counters.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter  int NREG       = 32,
    parameter  int MC_MAX_LAT = 64,
    parameter  int CNT_W      = 32,
    localparam int REG_AW     = $clog2(NREG)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [REG_AW-1:0] i_id_rs1,
    input  logic [REG_AW-1:0] i_id_rs2,
    input  logic              i_id_use_rs1,
    input  logic              i_id_use_rs2,
    input  logic [REG_AW-1:0] i_ex_rs1,
    input  logic [REG_AW-1:0] i_ex_rs2,
    input  logic [REG_AW-1:0] i_idex_rd,
    input  logic              i_idex_memread,
    input  logic              i_idex_mc,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_exmem_regwrite,
    input  logic              i_memwb_regwrite,
    input  logic              i_branch_taken,
    input  logic              i_mc_done,
    input  logic              i_halt_req,
    input  logic              i_resume,
    output logic [1:0]        o_fwd_a,
    output logic [1:0]        o_fwd_b,
    output logic              o_pc_en,
    output logic              o_ifid_en,
    output logic              o_idex_en,
    output logic              o_exmem_en,
    output logic              o_memwb_en,
    output logic              o_ifid_flush,
    output logic              o_idex_flush,
    output logic              o_exmem_flush,
    output logic              o_mc_start,
    output logic [1:0]        o_state,
    output logic              o_mc_timeout,
    output logic [CNT_W-1:0]  o_stall_cnt,
    output logic [CNT_W-1:0]  o_flush_cnt
);

    localparam int              c_WD_W    = (MC_MAX_LAT > 1) ? $clog2(MC_MAX_LAT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(MC_MAX_LAT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_WD_W-1:0]  r_wdog;
    logic               r_mc_timeout;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic [CNT_W-1:0]   r_flush_cnt;
    pipe_ctrl_t         w_ctrl;
    logic               w_load_use;
    logic               w_mc_start;
    logic               w_timeout_set;
    logic               w_flush_inc;
    logic               w_stall_inc;

    hazard_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_hazard_fwd (
        .i_id_rs1         (i_id_rs1),
        .i_id_rs2         (i_id_rs2),
        .i_id_use_rs1     (i_id_use_rs1),
        .i_id_use_rs2     (i_id_use_rs2),
        .i_ex_rs1         (i_ex_rs1),
        .i_ex_rs2         (i_ex_rs2),
        .i_idex_rd        (i_idex_rd),
        .i_idex_memread   (i_idex_memread),
        .i_exmem_rd       (i_exmem_rd),
        .i_exmem_regwrite (i_exmem_regwrite),
        .i_memwb_rd       (i_memwb_rd),
        .i_memwb_regwrite (i_memwb_regwrite),
        .o_fwd_a          (o_fwd_a),
        .o_fwd_b          (o_fwd_b),
        .o_load_use       (w_load_use)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority in RUN: branch squash, then multicycle launch, then load-use / halt.
    always_comb begin
        w_state_nxt   = r_state;
        w_ctrl        = c_CTRL_FLOW;
        w_mc_start    = 1'b0;
        w_timeout_set = 1'b0;
        w_flush_inc   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (i_branch_taken) begin
                    w_ctrl.ifid_flush  = 1'b1;
                    w_ctrl.idex_flush  = 1'b1;
                    w_ctrl.exmem_flush = 1'b1;
                    w_flush_inc        = 1'b1;
                end else if (i_idex_mc) begin
                    w_mc_start         = 1'b1;
                    w_ctrl.pc_en       = 1'b0;
                    w_ctrl.ifid_en     = 1'b0;
                    w_ctrl.idex_en     = 1'b0;
                    w_ctrl.exmem_flush = 1'b1;
                    w_state_nxt        = ST_WAIT_MC;
                end else begin
                    if (w_load_use) begin
                        w_ctrl.pc_en      = 1'b0;
                        w_ctrl.ifid_en    = 1'b0;
                        w_ctrl.idex_flush = 1'b1;
                    end
                    if (i_halt_req) begin
                        w_state_nxt = ST_HALT;
                    end
                end
            end
            ST_WAIT_MC: begin
                if (!i_mc_done && (r_wdog != c_WD_LAST)) begin
                    w_ctrl.pc_en       = 1'b0;
                    w_ctrl.ifid_en     = 1'b0;
                    w_ctrl.idex_en     = 1'b0;
                    w_ctrl.exmem_flush = 1'b1;
                end else begin
                    w_timeout_set = !i_mc_done;
                    w_state_nxt   = ST_RUN;
                end
            end
            ST_HALT: begin
                w_ctrl = c_CTRL_FROZEN;
                if (i_resume) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_stall_inc = !w_ctrl.pc_en && (r_state != ST_HALT);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_wdog       <= '0;
            r_mc_timeout <= 1'b0;
            r_stall_cnt  <= '0;
            r_flush_cnt  <= '0;
        end else begin
            if (r_state == ST_WAIT_MC) begin
                r_wdog <= r_wdog + c_WD_W'(1);
            end else begin
                r_wdog <= '0;
            end
            if (w_timeout_set) begin
                r_mc_timeout <= 1'b1;
            end
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_flush_inc && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pc_en       = w_ctrl.pc_en;
    assign o_ifid_en     = w_ctrl.ifid_en;
    assign o_idex_en     = w_ctrl.idex_en;
    assign o_exmem_en    = w_ctrl.exmem_en;
    assign o_memwb_en    = w_ctrl.memwb_en;
    assign o_ifid_flush  = w_ctrl.ifid_flush;
    assign o_idex_flush  = w_ctrl.idex_flush;
    assign o_exmem_flush = w_ctrl.exmem_flush;
    // The start pulse must never reach the multicycle unit while reset is held.
    assign o_mc_start    = w_mc_start && i_reset_n;
    assign o_state       = r_state;
    assign o_mc_timeout  = r_mc_timeout;
    assign o_stall_cnt   = r_stall_cnt;
    assign o_flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int NREG   = 32;
    localparam int MC_LAT = 8;
    localparam int CW     = 4;
    localparam int AW     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0;
    logic [AW-1:0] idex_rd = '0, exmem_rd = '0, memwb_rd = '0;
    logic          use_rs1 = 1'b0, use_rs2 = 1'b0, memread = 1'b0, idex_mc = 1'b0;
    logic          exmem_rw = 1'b0, memwb_rw = 1'b0, branch = 1'b0, mc_done = 1'b0;
    logic          halt_req = 1'b0, resume = 1'b0;
    logic [1:0]    fwd_a, fwd_b, state;
    logic          pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic          ifid_fl, idex_fl, exmem_fl, mc_start, mc_timeout;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_pass  = 0;
    int n_total = 0;

    pipe_hazard_ctrl #(
        .NREG       (NREG),
        .MC_MAX_LAT (MC_LAT),
        .CNT_W      (CW)
    ) dut (
        .i_clk            (clk),
        .i_reset_n        (rst_n),
        .i_id_rs1         (id_rs1),
        .i_id_rs2         (id_rs2),
        .i_id_use_rs1     (use_rs1),
        .i_id_use_rs2     (use_rs2),
        .i_ex_rs1         (ex_rs1),
        .i_ex_rs2         (ex_rs2),
        .i_idex_rd        (idex_rd),
        .i_idex_memread   (memread),
        .i_idex_mc        (idex_mc),
        .i_exmem_rd       (exmem_rd),
        .i_memwb_rd       (memwb_rd),
        .i_exmem_regwrite (exmem_rw),
        .i_memwb_regwrite (memwb_rw),
        .i_branch_taken   (branch),
        .i_mc_done        (mc_done),
        .i_halt_req       (halt_req),
        .i_resume         (resume),
        .o_fwd_a          (fwd_a),
        .o_fwd_b          (fwd_b),
        .o_pc_en          (pc_en),
        .o_ifid_en        (ifid_en),
        .o_idex_en        (idex_en),
        .o_exmem_en       (exmem_en),
        .o_memwb_en       (memwb_en),
        .o_ifid_flush     (ifid_fl),
        .o_idex_flush     (idex_fl),
        .o_exmem_flush    (exmem_fl),
        .o_mc_start       (mc_start),
        .o_state          (state),
        .o_mc_timeout     (mc_timeout),
        .o_stall_cnt      (stall_cnt),
        .o_flush_cnt      (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Enables packed {pc, ifid, idex, exmem, memwb}; flushes {ifid, idex, exmem}.
    task automatic check_ctrl(input string tag, input logic [4:0] en_exp, input logic [2:0] fl_exp);
        check({tag, ".en"}, 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(en_exp));
        check({tag, ".fl"}, 32'({ifid_fl, idex_fl, exmem_fl}), 32'(fl_exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        // ---------------- reset ----------------
        step();
        step();
        mid();
        check("rst.state", 32'(state), 32'h0);
        check("rst.stall", 32'(stall_cnt), 32'h0);
        check("rst.flush", 32'(flush_cnt), 32'h0);
        check("rst.tmo", 32'(mc_timeout), 32'h0);
        check("rst.start", 32'(mc_start), 32'h0);
        check_ctrl("rst", 5'b11111, 3'b000);
        step();
        rst_n = 1'b1;

        // ---------------- forwarding ----------------
        exmem_rd = 5'd5; exmem_rw = 1'b1; memwb_rd = 5'd5; memwb_rw = 1'b1; ex_rs1 = 5'd5;
        #1 check("fwd.a_exmem_wins", 32'(fwd_a), 32'h2);
        exmem_rd = 5'd0;
        #1 check("fwd.a_memwb", 32'(fwd_a), 32'h1);
        ex_rs2 = 5'd0; memwb_rd = 5'd0;
        #1 check("fwd.b_x0", 32'(fwd_b), 32'h0);
        exmem_rd = 5'd9; ex_rs2 = 5'd9;
        #1 check("fwd.b_exmem", 32'(fwd_b), 32'h2);
        exmem_rw = 1'b0;
        #1 check("fwd.b_nowrite", 32'(fwd_b), 32'h0);
        exmem_rd = '0; memwb_rw = 1'b0; ex_rs1 = '0; ex_rs2 = '0;

        // ---------------- load-use ----------------
        step();
        memread = 1'b1; idex_rd = 5'd7; id_rs2 = 5'd7; use_rs2 = 1'b1;
        mid();
        check_ctrl("lu.stall", 5'b00111, 3'b010);
        step();
        memread = 1'b0;
        mid();
        check_ctrl("lu.after", 5'b11111, 3'b000);
        check("lu.stall_cnt", 32'(stall_cnt), 32'h1);
        step();
        memread = 1'b1; idex_rd = 5'd0; id_rs2 = 5'd0;
        mid();
        check_ctrl("lu.rd0", 5'b11111, 3'b000);
        step();
        idex_rd = 5'd7; id_rs2 = 5'd7; use_rs2 = 1'b0;
        mid();
        check("lu.no_use", 32'(pc_en), 32'h1);
        step();
        check("lu.cnt_hold", 32'(stall_cnt), 32'h1);

        // ---------------- branch overrides everything ----------------
        use_rs2 = 1'b1; branch = 1'b1; halt_req = 1'b1;
        mid();
        check_ctrl("br", 5'b11111, 3'b111);
        step();
        branch = 1'b0; halt_req = 1'b0; memread = 1'b0; use_rs2 = 1'b0;
        mid();
        check("br.flush_cnt", 32'(flush_cnt), 32'h1);
        check("br.state", 32'(state), 32'h0);
        check("br.stall_cnt", 32'(stall_cnt), 32'h1);

        // ---------------- mc_done in RUN is ignored ----------------
        step();
        mc_done = 1'b1;
        mid();
        check_ctrl("done_in_run", 5'b11111, 3'b000);
        step();
        mc_done = 1'b0;
        check("done_in_run.state", 32'(state), 32'h0);

        // ---------------- multicycle with done ----------------
        idex_mc = 1'b1;
        mid();
        check("mc.start", 32'(mc_start), 32'h1);
        check_ctrl("mc.launch", 5'b00011, 3'b001);
        for (int i = 1; i <= 5; i++) begin
            step();
            mid();
            check($sformatf("mc.wait%0d.state", i), 32'(state), 32'h1);
            check($sformatf("mc.wait%0d.start", i), 32'(mc_start), 32'h0);
            check_ctrl($sformatf("mc.wait%0d", i), 5'b00011, 3'b001);
        end
        step();
        mc_done = 1'b1;
        mid();
        check_ctrl("mc.release", 5'b11111, 3'b000);
        step();
        mc_done = 1'b0; idex_mc = 1'b0;
        mid();
        check("mc.state_run", 32'(state), 32'h0);
        check("mc.stall_cnt", 32'(stall_cnt), 32'h7);

        // ---------------- watchdog timeout (8 waits) ----------------
        step();
        idex_mc = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step();
            mid();
            check($sformatf("to.wait%0d.pc", i), 32'(pc_en), 32'h0);
        end
        step();
        mid();
        check("to.release.pc", 32'(pc_en), 32'h1);
        check("to.pre", 32'(mc_timeout), 32'h0);
        step();
        idex_mc = 1'b0;
        mid();
        check("to.set", 32'(mc_timeout), 32'h1);
        check("to.state_run", 32'(state), 32'h0);
        check("to.stall_sat_hit", 32'(stall_cnt), 32'hF);

        // ---------------- saturation and sticky timeout ----------------
        step();
        memread = 1'b1; idex_rd = 5'd3; id_rs1 = 5'd3; use_rs1 = 1'b1;
        mid();
        check("sat.stalling", 32'(pc_en), 32'h0);
        step();
        memread = 1'b0; use_rs1 = 1'b0;
        mid();
        check("sat.stall_cnt", 32'(stall_cnt), 32'hF);
        check("to.sticky", 32'(mc_timeout), 32'h1);

        // ---------------- halt request deferred past WAIT_MC ----------------
        step();
        idex_mc = 1'b1;
        step();
        halt_req = 1'b1;
        mid();
        check("hlt.in_wait", 32'(state), 32'h1);
        step();
        mc_done = 1'b1;
        mid();
        check("hlt.wait_done", 32'(state), 32'h1);
        step();
        mc_done = 1'b0; idex_mc = 1'b0;
        mid();
        check("hlt.back_run", 32'(state), 32'h0);
        check_ctrl("hlt.run", 5'b11111, 3'b000);
        step();
        halt_req = 1'b0; branch = 1'b1; ex_rs1 = 5'd4; exmem_rd = 5'd4; exmem_rw = 1'b1;
        mid();
        check("hlt.state", 32'(state), 32'h2);
        check_ctrl("hlt", 5'b00000, 3'b000);
        check("hlt.fwd", 32'(fwd_a), 32'h2);
        step();
        branch = 1'b0; resume = 1'b1;
        mid();
        check("hlt.flush_frozen", 32'(flush_cnt), 32'h1);
        check("hlt.still", 32'(state), 32'h2);
        step();
        resume = 1'b0;
        mid();
        check("hlt.resumed", 32'(state), 32'h0);

        // ---------------- async reset in HALT ----------------
        step();
        halt_req = 1'b1;
        step();
        halt_req = 1'b0;
        mid();
        check("arst.in_halt", 32'(state), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        check("arst.state", 32'(state), 32'h0);
        check("arst.stall", 32'(stall_cnt), 32'h0);
        check("arst.flush", 32'(flush_cnt), 32'h0);
        check("arst.tmo", 32'(mc_timeout), 32'h0);
        check_ctrl("arst", 5'b11111, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and control unit for the next-generation 5-stage RISC-V pipeline (IF/ID/EX/MEM/WB).
- Generates EX operand forwarding selects.
- Detects load-use hazards and inserts one bubble.
- Flushes younger stages on a branch resolved in MEM.
- Sequences multicycle EX operations (mul/div) with a start/done handshake and watchdog.
- Supports debug halt/resume and keeps saturating stall/flush counters.
- Drives the enable and flush inputs of every pipeline register in the CPU top level.

Parameters:
NREG, 32, architectural register count; REG_AW = clog2(NREG).
MC_MAX_LAT, 64, maximum cycles to wait for i_mc_done before timeout.
CNT_W, 32, width of the performance counters.

Ports:
i_clk  in  1  clock, rising edge.
i_reset_n  in  1  asynchronous active-low reset.
i_id_rs1, i_id_rs2  in  REG_AW  source registers of the instruction in ID.
i_id_use_rs1, i_id_use_rs2  in  1  the ID instruction reads rs1/rs2.
i_ex_rs1, i_ex_rs2  in  REG_AW  source registers held in ID/EX.
i_idex_rd  in  REG_AW  destination register in ID/EX.
i_idex_memread  in  1  the ID/EX instruction is a load.
i_idex_mc  in  1  the ID/EX instruction is a multicycle op.
i_exmem_rd, i_memwb_rd  in  REG_AW  destinations in EX/MEM and MEM/WB.
i_exmem_regwrite, i_memwb_regwrite  in  1  write-enables in EX/MEM and MEM/WB.
i_branch_taken  in  1  PCSrc from MEM.
i_mc_done  in  1  one-cycle done pulse from the multicycle unit.
i_halt_req, i_resume  in  1  debug halt request / resume.
o_fwd_a, o_fwd_b  out  2  forwarding select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1  register enables.
o_ifid_flush, o_idex_flush, o_exmem_flush  out  1  load a bubble (all controls 0).
o_mc_start  out  1  one-cycle start pulse to the multicycle unit.
o_state  out  2  00 RUN, 01 WAIT_MC, 10 HALT.
o_mc_timeout  out  1  sticky watchdog error.
o_stall_cnt, o_flush_cnt  out  CNT_W  saturating counters.

Behaviour:
- Reset (async, i_reset_n=0):
  - state=RUN; counters=0; o_mc_timeout=0; o_mc_start=0.
  - Combinational outputs follow RUN rules.
- Forwarding (combinational, all states):
  - fwd_a=10 if i_exmem_regwrite && i_exmem_rd!=0 && i_exmem_rd==i_ex_rs1.
  - Otherwise 01 on the same test against MEM/WB.
  - Otherwise 00.
  - Same rules for fwd_b against i_ex_rs2.
  - EX/MEM beats MEM/WB. x0 never forwards.
- Load-use (RUN only):
  - Hazard when i_idex_memread && i_idex_rd!=0 && ((use_rs1 && rd==rs1) || (use_rs2 && rd==rs2)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1. Exactly one bubble per hazard.
- Branch (RUN, i_branch_taken=1):
  - ifid_flush=idex_flush=exmem_flush=1; pc_en=1 so the PC loads the target.
  - Overrides load-use, the multicycle start and a halt request in the same cycle.
  - o_flush_cnt += 1.
- RUN -> WAIT_MC:
  - Condition: i_idex_mc=1 and no branch.
  - o_mc_start=1 for that cycle; pc/ifid/idex enables=0; exmem_flush=1; watchdog cleared.
- WAIT_MC:
  - Holds pc/ifid/idex and sets exmem_flush=1 every cycle.
  - Watchdog increments each cycle.
  - On i_mc_done: all enables=1, no flush (result captured into EX/MEM), next state RUN.
  - On watchdog==MC_MAX_LAT-1 without done: set o_mc_timeout, release as if done.
  - i_mc_done while in RUN is ignored.
  - i_branch_taken cannot arrive in WAIT_MC because EX/MEM holds bubbles; if asserted, ignore it.
- HALT:
  - Entered from RUN when i_halt_req=1 and no branch/mc event; a request seen in WAIT_MC is deferred until RUN.
  - In HALT all five enables=0, no flushes, counters frozen.
  - i_resume -> RUN next cycle; i_resume outside HALT is ignored.
- Counters:
  - o_stall_cnt += 1 each cycle pc_en=0 in RUN or WAIT_MC.
  - Both counters saturate at all-ones.
- Outside HALT: o_exmem_en = o_memwb_en = 1.

Decomposition:
- Package pipe_ctrl_pkg: state encoding (RUN/WAIT_MC/HALT), forwarding select constants (FWD_RF/FWD_EXMEM/FWD_MEMWB), bubble control defaults.
- Sub-module hazard_fwd_unit: purely combinational forwarding plus load-use detect, parametrised by REG_AW.
- The FSM, watchdog and counters stay in pipe_hazard_ctrl.

Test Plan:
- EX/MEM rd=5 regwrite, MEM/WB rd=5 regwrite, ex_rs1=5 -> fwd_a=10. With exmem_rd=0 -> fwd_a=01. exmem_rd=0, ex_rs2=0 -> fwd_b=00.
- idex_memread, idex_rd=7, id_rs2=7, use_rs2=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cnt=1. Same with idex_rd=0 -> no stall.
- i_branch_taken with a simultaneous load-use hazard and halt_req -> three flushes, pc_en=1, flush_cnt=1, state stays RUN.
- idex_mc=1, i_mc_done 5 cycles later -> mc_start single pulse; WAIT_MC for 5 cycles with exmem_flush=1; stall_cnt=6; RUN after done.
- MC_MAX_LAT=8, no done -> o_mc_timeout=1 after 8 cycles, RUN resumed; timeout stays set until i_reset_n low.
- halt_req during WAIT_MC -> HALT entered the cycle after returning to RUN; all enables 0; i_resume -> RUN. Async reset mid-HALT -> RUN, counters 0.
